dcache_ctrl: RTL

DCACHE_CTRL -- requirements
Module: dcache_ctrl

---
 rtl/dcache_pkg.sv | 40 ++++
 rtl/dcache_word_merge.sv | 21 ++
 rtl/dcache_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// dcache_pkg: geometry, tag-entry layout and FSM encoding shared by the data cache controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dcache_pkg;

  localparam int TAG_W      = 55;
  localparam int IDX_W      = 4;
  localparam int LINE_W     = 256;
  localparam int WORD_SEL_W = 2;
  localparam int WORD_W     = 64;
  localparam int OFFS_W     = 5;

  // Tag entry layout: {valid, dirty, tag}
  localparam int ENTRY_W         = TAG_W + 2;
  localparam int ENTRY_VALID_BIT = TAG_W + 1;
  localparam int ENTRY_DIRTY_BIT = TAG_W;

  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
  } tag_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COMPARE,
    ST_WRITEBACK,
    ST_ALLOCATE
  } state_t;

  // Every entry the controller writes is valid; only dirty and tag vary.
  function automatic tag_entry_t make_entry(input logic dirty, input logic [TAG_W-1:0] tag);
    tag_entry_t e;
    e.valid = 1'b1;
    e.dirty = dirty;
    e.tag   = tag;
    return e;
  endfunction

endpackage

// File: rtl/dcache_word_merge.sv
// dcache_word_merge: selects one 64-bit word of a line and builds the line with that word replaced.
// Latency: combinational.
// Backpressure: none.
// Ports: line_i/sel_i/wdata_i in; rd_word_o = selected word, line_o = line_i with word sel_i := wdata_i.
module dcache_word_merge
  import dcache_pkg::*;
(
  input  logic [LINE_W-1:0]     line_i,
  input  logic [WORD_SEL_W-1:0] sel_i,
  input  logic [WORD_W-1:0]     wdata_i,
  output logic [WORD_W-1:0]     rd_word_o,
  output logic [LINE_W-1:0]     line_o
);

  always_comb begin
    rd_word_o = line_i[int'(sel_i)*WORD_W +: WORD_W];
    line_o    = line_i;
    line_o[int'(sel_i)*WORD_W +: WORD_W] = wdata_i;
  end

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache controller (16 sets x 32-byte lines).
// Latency: hit completes 2 cycles after acceptance; a miss adds an optional write-back and a refill.
// Backpressure: one request at a time; cpu inputs are ignored outside IDLE, memory stalls via mem_ready_i.
// Ports: cpu_* request/response, tag_*/data_* external array access (index shared), mem_* line refill/evict.
// Option DCACHE_STATS_EN adds stat_hit_o/stat_miss_o counters of first-pass lookups.
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
`ifdef DCACHE_STATS_EN
  output logic [31:0]          stat_hit_o,
  output logic [31:0]          stat_miss_o,
`endif
  input  logic                 cpu_valid_i,
  input  logic                 cpu_we_i,
  input  logic [63:0]          cpu_addr_i,
  input  logic [WORD_W-1:0]    cpu_wdata_i,
  output logic                 cpu_ready_o,
  output logic [WORD_W-1:0]    cpu_rdata_o,
  output logic [IDX_W-1:0]     tag_index_o,
  output logic                 tag_we_o,
  output logic [ENTRY_W-1:0]   tag_write_o,
  input  logic [ENTRY_W-1:0]   tag_read_i,
  output logic                 data_we_o,
  output logic [LINE_W-1:0]    data_write_o,
  input  logic [LINE_W-1:0]    data_read_i,
  output logic                 mem_valid_o,
  output logic                 mem_we_o,
  output logic [63:0]          mem_addr_o,
  output logic [LINE_W-1:0]    mem_wdata_o,
  input  logic [LINE_W-1:0]    mem_rdata_i,
  input  logic                 mem_ready_i
);

  state_t                  state;
  logic                    req_we;
  logic [TAG_W-1:0]        req_tag;
  logic [IDX_W-1:0]        req_idx;
  logic [WORD_SEL_W-1:0]   req_word;
  logic [WORD_W-1:0]       req_wdata;

  logic                    ent_valid;
  logic                    ent_dirty;
  logic [TAG_W-1:0]        ent_tag;
  logic                    hit;
  logic [WORD_W-1:0]       rd_word;
  logic [LINE_W-1:0]       merged_line;
  tag_entry_t              wr_entry;
  logic                    addr_unused;

  // Byte offset within a word never matters for 64-bit accesses.
  assign addr_unused = ^cpu_addr_i[2:0];

  assign ent_valid = tag_read_i[ENTRY_VALID_BIT];
  assign ent_dirty = tag_read_i[ENTRY_DIRTY_BIT];
  assign ent_tag   = tag_read_i[TAG_W-1:0];
  assign hit       = ent_valid && (ent_tag == req_tag);

  // Looking up with the live address in IDLE lets the arrays settle before COMPARE.
  assign tag_index_o = (state == ST_IDLE) ? cpu_addr_i[8:5] : req_idx;
  assign tag_write_o = wr_entry;

  dcache_word_merge u_merge (
    .line_i    (data_read_i),
    .sel_i     (req_word),
    .wdata_i   (req_wdata),
    .rd_word_o (rd_word),
    .line_o    (merged_line)
  );

  // Array and memory strobes decode the state register; all are masked during reset so an
  // abandoned refill cannot land in the arrays.
  always_comb begin
    tag_we_o     = 1'b0;
    wr_entry     = '0;
    data_we_o    = 1'b0;
    data_write_o = '0;
    mem_valid_o  = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    if (!rst_i) begin
      case (state)
        ST_COMPARE: begin
          if (hit && req_we) begin
            tag_we_o     = 1'b1;
            wr_entry     = make_entry(1'b1, req_tag);
            data_we_o    = 1'b1;
            data_write_o = merged_line;
          end
        end
        ST_WRITEBACK: begin
          mem_valid_o = 1'b1;
          mem_we_o    = 1'b1;
          mem_addr_o  = {ent_tag, req_idx, {OFFS_W{1'b0}}};
          mem_wdata_o = data_read_i;
        end
        ST_ALLOCATE: begin
          mem_valid_o = 1'b1;
          mem_addr_o  = {req_tag, req_idx, {OFFS_W{1'b0}}};
          if (mem_ready_i) begin
            tag_we_o     = 1'b1;
            wr_entry     = make_entry(1'b0, req_tag);
            data_we_o    = 1'b1;
            data_write_o = mem_rdata_i;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  logic        first_cmp;   // set for the COMPARE that follows acceptance, not the refill re-check
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
  assign stat_hit_o  = hit_cnt;
  assign stat_miss_o = miss_cnt;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      req_we      <= 1'b0;
      req_tag     <= '0;
      req_idx     <= '0;
      req_word    <= '0;
      req_wdata   <= '0;
      cpu_ready_o <= 1'b0;
      cpu_rdata_o <= '0;
`ifdef DCACHE_STATS_EN
      first_cmp   <= 1'b0;
      hit_cnt     <= '0;
      miss_cnt    <= '0;
`endif
    end else begin
      cpu_ready_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cpu_valid_i) begin
            req_we    <= cpu_we_i;
            req_tag   <= cpu_addr_i[63:9];
            req_idx   <= cpu_addr_i[8:5];
            req_word  <= cpu_addr_i[4:3];
            req_wdata <= cpu_wdata_i;
            state     <= ST_COMPARE;
`ifdef DCACHE_STATS_EN
            first_cmp <= 1'b1;
`endif
          end
        end
        ST_COMPARE: begin
`ifdef DCACHE_STATS_EN
          first_cmp <= 1'b0;
          if (first_cmp) begin
            if (hit) hit_cnt  <= hit_cnt + 32'd1;
            else     miss_cnt <= miss_cnt + 32'd1;
          end
`endif
          if (hit) begin
            cpu_ready_o <= 1'b1;
            if (!req_we) cpu_rdata_o <= rd_word;
            state <= ST_IDLE;
          end else if (ent_valid && ent_dirty) begin
            state <= ST_WRITEBACK;
          end else begin
            state <= ST_ALLOCATE;
          end
        end
        ST_WRITEBACK: if (mem_ready_i) state <= ST_ALLOCATE;
        ST_ALLOCATE:  if (mem_ready_i) state <= ST_COMPARE;
        default:      state <= ST_IDLE;
      endcase
    end
  end

endmodule
